// File: rtl/timer_counter_ar.sv
// Up/down timer-counter with an external (synchronised clk_int edge) or internal (prescaler) tick,
// auto-reload at terminal count, overflow/underflow pulses with sticky flags, and compare-match pulse.
module timer_counter_ar #(
    parameter int WIDTH   = 16,
    parameter int PRESC_W = 8
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic               clk_int_i,
    input  logic               tick_sel_i,
    input  logic [PRESC_W-1:0] presc_div_i,
    input  logic               en_i,
    input  logic               dw_i,
    input  logic               auto_rld_i,
    input  logic               load_i,
    input  logic [WIDTH-1:0]   ld_val_i,
    input  logic [WIDTH-1:0]   rld_val_i,
    input  logic [WIDTH-1:0]   cmp_val_i,
    input  logic               clr_flags_i,
    output logic [WIDTH-1:0]   cnt_out_o,
    output logic               ovf_o,
    output logic               udf_o,
    output logic               cmp_match_o,
    output logic               ovf_flag_o,
    output logic               udf_flag_o
);

    logic               sync1_q, sync2_q, edge_dly_q;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               udf_q, udf_d;
    logic               cmp_q, cmp_d;
    logic               ovf_flag_q, ovf_flag_d;
    logic               udf_flag_q, udf_flag_d;
    logic               ext_tick, presc_hit, tick;

    // The delayed copy makes the edge detector registered; the tick itself
    // is used on the same edge so a rise sampled at edge N counts at N+2.
    assign ext_tick  = sync2_q & ~edge_dly_q;
    assign presc_hit = (presc_cnt_q == presc_div_i);
    assign tick      = en_i & (tick_sel_i ? presc_hit : ext_tick);

    always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (load_i) begin
            presc_cnt_d = '0;
        end else if (en_i) begin
            presc_cnt_d = presc_hit ? '0 : presc_cnt_q + PRESC_W'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        cmp_d = 1'b0;
        if (load_i) begin
            cnt_d = ld_val_i;
        end else if (tick) begin
            if (!dw_i) begin
                if (cnt_q == '1) begin
                    cnt_d = auto_rld_i ? rld_val_i : '0;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = auto_rld_i ? rld_val_i : '1;
                    udf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
            cmp_d = (cnt_d == cmp_val_i);
        end
    end

    // A new event outranks a simultaneous clear.
    assign ovf_flag_d = ovf_d | (ovf_flag_q & ~clr_flags_i);
    assign udf_flag_d = udf_d | (udf_flag_q & ~clr_flags_i);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            edge_dly_q  <= 1'b0;
            presc_cnt_q <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            cmp_q       <= 1'b0;
            ovf_flag_q  <= 1'b0;
            udf_flag_q  <= 1'b0;
        end else begin
            sync1_q     <= clk_int_i;
            sync2_q     <= sync1_q;
            edge_dly_q  <= sync2_q;
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            cmp_q       <= cmp_d;
            ovf_flag_q  <= ovf_flag_d;
            udf_flag_q  <= udf_flag_d;
        end
    end

    assign cnt_out_o   = cnt_q;
    assign ovf_o       = ovf_q;
    assign udf_o       = udf_q;
    assign cmp_match_o = cmp_q;
    assign ovf_flag_o  = ovf_flag_q;
    assign udf_flag_o  = udf_flag_q;

endmodule

// File: tb/tb_timer_counter_ar.sv
// Scoreboard bench for timer_counter_ar (WIDTH=8): expectations are queued as stimulus is
// driven and popped one per pclk cycle, sampled 1 ns after the rising edge.
module tb_timer_counter_ar;

    localparam int W = 8;
    localparam int P = 8;

    logic         pclk = 1'b0;
    logic         presetn = 1'b0;
    logic         clk_int = 1'b0;
    logic         tick_sel = 1'b0;
    logic [P-1:0] presc_div = '0;
    logic         en = 1'b0;
    logic         dw = 1'b0;
    logic         auto_rld = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] ld_val = '0;
    logic [W-1:0] rld_val = '0;
    logic [W-1:0] cmp_val = 8'hAA;
    logic         clr_flags = 1'b0;
    logic [W-1:0] cnt_out;
    logic         ovf, udf, cmp_match, ovf_flag, udf_flag;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         ovf;
        logic         udf;
        logic         cmp;
        logic         of;
        logic         uf;
    } obs_t;

    obs_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 pclk = ~pclk;

    timer_counter_ar #(.WIDTH(W), .PRESC_W(P)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .clk_int_i   (clk_int),
        .tick_sel_i  (tick_sel),
        .presc_div_i (presc_div),
        .en_i        (en),
        .dw_i        (dw),
        .auto_rld_i  (auto_rld),
        .load_i      (load),
        .ld_val_i    (ld_val),
        .rld_val_i   (rld_val),
        .cmp_val_i   (cmp_val),
        .clr_flags_i (clr_flags),
        .cnt_out_o   (cnt_out),
        .ovf_o       (ovf),
        .udf_o       (udf),
        .cmp_match_o (cmp_match),
        .ovf_flag_o  (ovf_flag),
        .udf_flag_o  (udf_flag)
    );

    function automatic obs_t sample();
        return '{cnt_out, ovf, udf, cmp_match, ovf_flag, udf_flag};
    endfunction

    function automatic obs_t mk(input logic [W-1:0] c, input logic o, input logic u,
                                input logic m, input logic of, input logic uf);
        return '{c, o, u, m, of, uf};
    endfunction

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        presetn = 1'b0; en = 1'b0; load = 1'b0; clr_flags = 1'b0; clk_int = 1'b0;
        dw = 1'b0; auto_rld = 1'b0; tick_sel = 1'b0; presc_div = '0; cmp_val = 8'hAA;
        step();
        step();
        presetn = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        do_reset();
        presetn = 1'b0;
        #2;
        sb.push_back(mk(8'h00, 0, 0, 0, 0, 0));
        e = sb.pop_front(); o = sample(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset_init got %h exp %h", o, e); end
        presetn = 1'b1;
        tick_sel = 1'b1; presc_div = '0; en = 1'b1;
        for (int i = 1; i <= 3; i++) sb.push_back(mk(W'(i), 0, 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++) begin
            step();
            e = sb.pop_front(); o = sample(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL reset_count%0d got %h exp %h", i, o, e); end
        end
        #2 presetn = 1'b0;
        #1;
        sb.push_back(mk(8'h00, 0, 0, 0, 0, 0));
        e = sb.pop_front(); o = sample(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset_midcount got %h exp %h", o, e); end
        step();
        presetn = 1'b1;
        sb.push_back(mk(8'h01, 0, 0, 0, 0, 0));
        step();
        e = sb.pop_front(); o = sample(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset_first_tick got %h exp %h", o, e); end
    endtask

    task automatic test_ext();
        obs_t o, e;
        logic [W-1:0] cur, nxt;
        logic         of;
        do_reset();
        tick_sel = 1'b0; en = 1'b1; dw = 1'b0; auto_rld = 1'b0;
        load = 1'b1; ld_val = 8'hFE;
        step();
        load = 1'b0;
        cur = 8'hFE; of = 1'b0;
        for (int r = 0; r < 3; r++) begin
            nxt = (r == 0) ? 8'hFF : (r == 1) ? 8'h00 : 8'h01;
            clk_int = 1'b1;
            sb.push_back(mk(cur, 0, 0, 0, of, 0));
            sb.push_back(mk(cur, 0, 0, 0, of, 0));
            if (r == 1) of = 1'b1;
            sb.push_back(mk(nxt, r == 1, 0, 0, of, 0));
            for (int k = 0; k < 2; k++) sb.push_back(mk(nxt, 0, 0, 0, of, 0));
            for (int k = 0; k < 5; k++) begin
                step();
                e = sb.pop_front(); o = sample(); n_vec++;
                if (o !== e) begin n_err++; $display("FAIL ext_rise%0d_c%0d got %h exp %h", r, k, o, e); end
            end
            clk_int = 1'b0;
            for (int k = 0; k < 3; k++) sb.push_back(mk(nxt, 0, 0, 0, of, 0));
            for (int k = 0; k < 3; k++) begin
                step();
                e = sb.pop_front(); o = sample(); n_vec++;
                if (o !== e) begin n_err++; $display("FAIL ext_low%0d_c%0d got %h exp %h", r, k, o, e); end
            end
            cur = nxt;
        end
    endtask

    task automatic test_int();
        obs_t o, e;
        do_reset();
        tick_sel = 1'b1; presc_div = 8'd3; dw = 1'b1; auto_rld = 1'b1; rld_val = 8'd5;
        en = 1'b1; load = 1'b1; ld_val = 8'd1;
        step();
        load = 1'b0;
        for (int k = 0; k < 3; k++) sb.push_back(mk(8'd1, 0, 0, 0, 0, 0));
        sb.push_back(mk(8'd0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) sb.push_back(mk(8'd0, 0, 0, 0, 0, 0));
        sb.push_back(mk(8'd5, 0, 1, 0, 0, 1));
        for (int k = 0; k < 3; k++) sb.push_back(mk(8'd5, 0, 0, 0, 0, 1));
        sb.push_back(mk(8'd4, 0, 0, 0, 0, 1));
        for (int k = 0; k < 12; k++) begin
            step();
            e = sb.pop_front(); o = sample(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL int_presc_c%0d got %h exp %h", k, o, e); end
        end
    endtask

    task automatic test_cmp();
        obs_t o, e;
        do_reset();
        cmp_val = 8'd3; tick_sel = 1'b1; presc_div = '0; dw = 1'b0; en = 1'b1;
        for (int i = 1; i <= 5; i++) sb.push_back(mk(W'(i), 0, 0, i == 3, 0, 0));
        for (int i = 1; i <= 5; i++) begin
            step();
            e = sb.pop_front(); o = sample(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL cmp_count%0d got %h exp %h", i, o, e); end
        end
        en = 1'b0; load = 1'b1; ld_val = 8'd3;
        sb.push_back(mk(8'd3, 0, 0, 0, 0, 0));
        step();
        e = sb.pop_front(); o = sample(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL cmp_load_nopulse got %h exp %h", o, e); end
        ld_val = 8'hFF; auto_rld = 1'b1; rld_val = 8'd3;
        sb.push_back(mk(8'hFF, 0, 0, 0, 0, 0));
        sb.push_back(mk(8'd3, 1, 0, 1, 1, 0));
        sb.push_back(mk(8'd3, 0, 0, 0, 1, 0));
        step();
        e = sb.pop_front(); o = sample(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL cmp_load_ff got %h exp %h", o, e); end
        load = 1'b0; en = 1'b1;
        step();
        e = sb.pop_front(); o = sample(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL cmp_reload_match got %h exp %h", o, e); end
        en = 1'b0;
        step();
        e = sb.pop_front(); o = sample(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL cmp_after_reload got %h exp %h", o, e); end
    endtask

    task automatic test_flags();
        obs_t o, e;
        do_reset();
        tick_sel = 1'b1; presc_div = '0; auto_rld = 1'b0; dw = 1'b0;
        load = 1'b1; ld_val = 8'hFE;
        sb.push_back(mk(8'hFE, 0, 0, 0, 0, 0));
        sb.push_back(mk(8'hFF, 0, 0, 0, 0, 0));
        sb.push_back(mk(8'h00, 1, 0, 0, 1, 0));
        sb.push_back(mk(8'h00, 0, 0, 0, 0, 0));
        sb.push_back(mk(8'hFF, 0, 1, 0, 0, 1));
        sb.push_back(mk(8'hFF, 0, 0, 0, 0, 1));
        sb.push_back(mk(8'hFF, 0, 0, 0, 0, 0));
        for (int k = 0; k < 7; k++) begin
            step();
            e = sb.pop_front(); o = sample(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL flags_c%0d got %h exp %h", k, o, e); end
            case (k)
                0: begin load = 1'b0; en = 1'b1; end
                1: clr_flags = 1'b1;
                2: en = 1'b0;
                3: begin clr_flags = 1'b0; dw = 1'b1; en = 1'b1; end
                4: en = 1'b0;
                5: clr_flags = 1'b1;
                default: clr_flags = 1'b0;
            endcase
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        do_reset();
        tick_sel = 1'b1; presc_div = '0; dw = 1'b0; en = 1'b1; cmp_val = 8'h40;
        sb.push_back(mk(8'h01, 0, 0, 0, 0, 0));
        sb.push_back(mk(8'h40, 0, 0, 0, 0, 0));
        sb.push_back(mk(8'h41, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            step();
            e = sb.pop_front(); o = sample(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL b2b_load_tick_c%0d got %h exp %h", k, o, e); end
            load = (k == 0);
            ld_val = 8'h40;
        end
        en = 1'b0; tick_sel = 1'b0;
        for (int k = 0; k < 8; k++) sb.push_back(mk(8'h41, 0, 0, 0, 0, 0));
        for (int k = 0; k < 8; k++) begin
            clk_int = ~clk_int;
            step();
            e = sb.pop_front(); o = sample(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL b2b_en_off_c%0d got %h exp %h", k, o, e); end
        end
        clk_int = 1'b0;
        repeat (3) step();
        en = 1'b1;
        for (int k = 0; k < 2; k++) sb.push_back(mk(8'h41, 0, 0, 0, 0, 0));
        for (int k = 0; k < 2; k++) begin
            step();
            e = sb.pop_front(); o = sample(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL b2b_lost_edge_c%0d got %h exp %h", k, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_ext();
        test_int();
        test_cmp();
        test_flags();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
